// File: rtl/calc_entry_ctrl_pkg.sv
// calc_entry_ctrl_pkg: shared state codes, default width and sign-magnitude canonicalisation.
package calc_entry_ctrl_pkg;

    localparam int DATA_W_DEF = 3;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_OP = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    function automatic logic [7:0] canon_sm(input logic [7:0] value, input int width);
        logic [7:0] mag_mask;
        mag_mask = 8'((1 << (width - 1)) - 1);
        return ((value & mag_mask) == '0) ? '0 : value;
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if: entry controls, add_sub operand/result link and display outputs.
interface calc_entry_ctrl_if #(parameter int DATA_W = 3);
    logic [DATA_W-1:0] sw;
    logic              op_sw;
    logic              enter;
    logic              clear;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              op;
    logic [DATA_W:0]   C;
    logic [DATA_W:0]   result;
    logic              result_vld;
    logic [2:0]        phase;

    modport master (output sw, op_sw, enter, clear, C, input A, B, op, result, result_vld, phase);
    modport slave  (input sw, op_sw, enter, clear, C, output A, B, op, result, result_vld, phase);
endinterface

// File: rtl/calc_entry_ctrl_rise_holdoff.sv
// rise_holdoff: rising-edge detector with a re-trigger holdoff window.
module rise_holdoff #(
    parameter int HOLDOFF = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_in,
    output logic o_acc
);
    localparam int CW = $clog2(HOLDOFF + 2);

    logic          r_in_q;
    logic [CW-1:0] r_cnt;

    assign o_acc = i_in & ~r_in_q & (r_cnt == '0) & ~i_clr;

    // clear zeroes the window but keeps tracking the input, so a held button is not re-seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_in_q <= i_in;
            r_cnt  <= i_clr ? '0 : o_acc ? CW'(HOLDOFF) : (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        end
    end
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: operand/operator entry sequencer and canonical result latch for add_sub.
module calc_entry_ctrl
    import calc_entry_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 2,
    parameter int HOLDOFF    = 4
) (
    input logic clk,
    input logic rst_n,
    calc_entry_ctrl_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t            r_state;
    state_t            w_next;
    logic [SW-1:0]     r_settle;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_op;
    logic [DATA_W:0]   r_result;
    logic              r_vld;
    logic              w_acc;
    logic              w_clr;
    logic              w_ld_a;
    logic              w_ld_op;
    logic              w_ld_b;
    logic              w_cap;
    logic [DATA_W-1:0] w_sw_c;
    logic [DATA_W:0]   w_c_c;

    rise_holdoff #(.HOLDOFF(HOLDOFF)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (bus.clear),
        .i_in  (bus.enter),
        .o_acc (w_acc)
    );

    assign w_clr  = !rst_n || bus.clear;
    assign w_sw_c = DATA_W'(canon_sm(8'(bus.sw), DATA_W));
    assign w_c_c  = (DATA_W+1)'(canon_sm(8'(bus.C), DATA_W + 1));

    always_ff @(posedge clk) begin
        if (w_clr) r_state <= GET_A;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            GET_A:   w_next = w_acc ? GET_OP : GET_A;
            GET_OP:  w_next = w_acc ? GET_B : GET_OP;
            GET_B:   w_next = w_acc ? EXEC : GET_B;
            EXEC:    w_next = (r_settle == '0) ? SHOW : EXEC;
            SHOW:    w_next = w_acc ? GET_A : SHOW;
            default: w_next = GET_A;
        endcase
    end

    always_comb begin
        w_ld_a  = (r_state == GET_A) && w_acc;
        w_ld_op = (r_state == GET_OP) && w_acc;
        w_ld_b  = (r_state == GET_B) && w_acc;
        w_cap   = (r_state == EXEC) && (r_settle == '0);
    end

    // operands stay registered through EXEC so add_sub sees constant inputs while settling
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_settle <= '0;
            r_result <= '0;
            r_vld    <= 1'b0;
        end else begin
            if (w_ld_a) r_a <= w_sw_c;
            if (w_ld_op) r_op <= bus.op_sw;
            if (w_ld_b) begin
                r_b      <= w_sw_c;
                r_settle <= SW'(SETTLE_CYC - 1);
            end else if (r_state == EXEC && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
            if (w_cap) begin
                r_result <= w_c_c;
                r_vld    <= 1'b1;
            end else if (w_ld_a) begin
                r_vld    <= 1'b0;
            end
        end
    end

    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.op         = r_op;
    assign bus.result     = r_result;
    assign bus.result_vld = r_vld;
    assign bus.phase      = r_state;
endmodule
